// File: rtl/vga_sync_decoder_if.sv
//------------------------------------------------------------------------------
// Module  : vga_sync_decoder_if
// Brief   : Sync input / recovered timing bundle for the VGA sync decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_sync_decoder_if;
   logic       pix_ce;
   logic       hsync_in;
   logic       vsync_in;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       valid;
   logic       locked;
   logic       frame_start;
   logic       line_err;
   logic       frame_err;
   logic [7:0] err_count;

   // master: the sync source / consumer of recovered timing
   modport master (
      output pix_ce, hsync_in, vsync_in,
      input  h_cnt, v_cnt, valid, locked, frame_start, line_err, frame_err, err_count
   );

   modport slave (
      input  pix_ce, hsync_in, vsync_in,
      output h_cnt, v_cnt, valid, locked, frame_start, line_err, frame_err, err_count
   );
endinterface

`default_nettype wire

// File: rtl/vga_sync_decoder.sv
//------------------------------------------------------------------------------
// Module  : vga_sync_decoder
// Brief   : Recovers pixel coordinates from hsync/vsync, checks timing, reports lock.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_decoder #(
   parameter int unsigned H_VISIBLE   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_VISIBLE   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic              clk,
   input  logic              rst,
   vga_sync_decoder_if.slave bus
);

   localparam logic [9:0] c_h_last     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_v_last     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
   localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
   localparam logic [7:0] c_lock_frames = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEEK_H = 2'd0,
      SEEK_V = 2'd1,
      TRACK  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       hs_q, hs_d;
   logic       vs_line_q, vs_line_d;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [7:0] good_q, good_d;
   logic       locked_q, locked_d;
   logic       valid_q, valid_d;
   logic       frame_start_q, frame_start_d;
   logic       line_err_q, line_err_d;
   logic       frame_err_q, frame_err_d;
   logic [7:0] err_count_q, err_count_d;

   logic       w_hfall;
   logic       w_vfall;
   logic       w_h_wrap;
   logic [9:0] w_h_pred;
   logic [9:0] w_v_pred;
   logic       w_h_chk;
   logic       w_v_chk;
   logic       w_any_err;
   logic [7:0] w_good_inc;
   logic [8:0] w_err_sum;

   // Edge detection and counter prediction (what the counters would be without resync)
   always_comb begin
      w_hfall  = hs_q & ~bus.hsync_in;
      w_vfall  = w_hfall & vs_line_q & ~bus.vsync_in;
      w_h_wrap = (h_cnt_q == c_h_last);
      w_h_pred = w_h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (w_h_wrap) begin
         w_v_pred = (v_cnt_q == c_v_last) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
         w_v_pred = v_cnt_q;
      end
   end

   // Timing checks
   always_comb begin
      w_h_chk = (state_q != SEEK_H);
      w_v_chk = (state_q == TRACK) || (state_q == LOCKED);

      line_err_d = 1'b0;
      if (w_h_chk) begin
         if (w_hfall) begin
            line_err_d = (w_h_pred != c_hs_start);
         end else begin
            line_err_d = (w_h_pred == c_hs_start) && bus.hsync_in;
         end
      end

      frame_err_d = 1'b0;
      if (w_v_chk) begin
         if (w_vfall) begin
            frame_err_d = (w_v_pred != c_vs_start);
         end else begin
            frame_err_d = w_hfall && (w_v_pred == c_vs_start) && bus.vsync_in;
         end
      end

      w_any_err = line_err_d | frame_err_d;
      w_err_sum = {1'b0, err_count_q} + {8'd0, line_err_d} + {8'd0, frame_err_d};
      err_count_d = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
   end

   // Lock state machine
   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      w_good_inc = good_q + 8'd1;
      case (state_q)
         SEEK_H: begin
            if (w_hfall) begin
               state_d = SEEK_V;
            end
         end
         SEEK_V: begin
            if (w_vfall) begin
               state_d = TRACK;
               good_d  = 8'd0;
            end
         end
         TRACK: begin
            if (w_any_err) begin
               good_d = 8'd0;
            end else if (w_vfall) begin
               good_d = w_good_inc;
               if (w_good_inc >= c_lock_frames) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (w_any_err) begin
               state_d = TRACK;
               good_d  = 8'd0;
            end
         end
         default: begin
            state_d = SEEK_H;
            good_d  = 8'd0;
         end
      endcase
   end

   // Counter and output next-state
   always_comb begin
      hs_d          = bus.hsync_in;
      vs_line_d     = w_hfall ? bus.vsync_in : vs_line_q;
      h_cnt_d       = w_hfall ? c_hs_start : w_h_pred;
      v_cnt_d       = w_vfall ? c_vs_start : w_v_pred;
      locked_d      = (state_d == LOCKED);
      valid_d       = locked_d && (h_cnt_d < c_h_vis) && (v_cnt_d < c_v_vis);
      frame_start_d = locked_d && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
   end

   // Pulses last one clk; everything else holds between pixel strobes
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= SEEK_H;
         hs_q          <= 1'b1;
         vs_line_q     <= 1'b1;
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         good_q        <= 8'd0;
         locked_q      <= 1'b0;
         valid_q       <= 1'b0;
         frame_start_q <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         err_count_q   <= 8'd0;
      end else begin
         frame_start_q <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         if (bus.pix_ce) begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_line_q     <= vs_line_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
         end
      end
   end

   assign bus.h_cnt       = h_cnt_q;
   assign bus.v_cnt       = v_cnt_q;
   assign bus.valid       = valid_q;
   assign bus.locked      = locked_q;
   assign bus.frame_start = frame_start_q;
   assign bus.line_err    = line_err_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.err_count   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_vga_sync_decoder
// Brief   : Directed self-checking bench for vga_sync_decoder on a reduced raster.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_decoder;

   // Reduced raster: 35 pixels x 21 lines, hsync at 24..29, vsync on lines 15..16
   localparam int HV = 20, HF = 4, HS = 6, HB = 5;
   localparam int VV = 12, VF = 3, VS = 2, VB = 4;
   localparam int H_TOT = HV + HF + HS + HB;
   localparam int V_TOT = VV + VF + VS + VB;
   localparam int H_SS  = HV + HF;
   localparam int V_SS  = VV + VF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_sync_decoder_if bus ();

   vga_sync_decoder #(
      .H_VISIBLE  (HV),
      .H_FRONT    (HF),
      .H_SYNC     (HS),
      .H_BACK     (HB),
      .V_VISIBLE  (VV),
      .V_FRONT    (VF),
      .V_SYNC     (VS),
      .V_BACK     (VB),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int sh, sv;
   bit hs_force_hi = 1'b0;
   bit vs_force_hi = 1'b0;
   int cnt_le, cnt_fe, cnt_fs, cnt_valid, cnt_fs_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_tally();
      cnt_le = 0; cnt_fe = 0; cnt_fs = 0; cnt_valid = 0; cnt_fs_bad = 0;
   endtask

   task automatic tally();
      cnt_le    += int'(bus.line_err);
      cnt_fe    += int'(bus.frame_err);
      cnt_fs    += int'(bus.frame_start);
      cnt_valid += int'(bus.valid);
      if (bus.frame_start && (bus.h_cnt != 10'd0 || bus.v_cnt != 10'd0)) cnt_fs_bad++;
   endtask

   // One pixel per clock from a nominal timing source at (sv, sh)
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         bus.pix_ce   = 1'b1;
         bus.hsync_in = hs_force_hi || !(sh >= H_SS && sh < H_SS + HS);
         bus.vsync_in = vs_force_hi || !(sv >= V_SS && sv < V_SS + VS);
         @(posedge clk); #1;
         tally();
         sh++;
         if (sh == H_TOT) begin
            sh = 0;
            sv = (sv == V_TOT - 1) ? 0 : sv + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.pix_ce   = 1'b0;
         bus.hsync_in = 1'($urandom_range(0, 1));
         bus.vsync_in = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         tally();
      end
   endtask

   task automatic chk_cleared(input string pfx);
      chk({pfx, "_h_cnt"},       32'(bus.h_cnt),       0);
      chk({pfx, "_v_cnt"},       32'(bus.v_cnt),       0);
      chk({pfx, "_valid"},       32'(bus.valid),       0);
      chk({pfx, "_locked"},      32'(bus.locked),      0);
      chk({pfx, "_frame_start"}, 32'(bus.frame_start), 0);
      chk({pfx, "_line_err"},    32'(bus.line_err),    0);
      chk({pfx, "_frame_err"},   32'(bus.frame_err),   0);
      chk({pfx, "_err_count"},   32'(bus.err_count),   0);
   endtask

   initial begin
      // T1: reset with random stimulus
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.pix_ce   = 1'($urandom_range(0, 1));
         bus.hsync_in = 1'($urandom_range(0, 1));
         bus.vsync_in = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      chk_cleared("t1");
      rst = 1'b1;
      sh = 5; sv = 10;
      clear_tally();

      // T2: acquisition and lock
      step(20);
      chk("t2_h_after_hfall", 32'(bus.h_cnt), H_SS);
      chk("t2_not_locked", 32'(bus.locked), 0);
      step(175);
      chk("t2_v_after_vfall", 32'(bus.v_cnt), V_SS);
      chk("t2_h_at_vfall", 32'(bus.h_cnt), H_SS);
      step(2 * H_TOT * V_TOT - 1);
      chk("t2_locked_before", 32'(bus.locked), 0);
      step(1);
      chk("t2_locked_after", 32'(bus.locked), 1);
      chk("t2_line_err_cnt", cnt_le, 0);
      chk("t2_frame_err_cnt", cnt_fe, 0);
      chk("t2_valid_prelock", cnt_valid, 0);
      chk("t2_err_count", 32'(bus.err_count), 0);

      // T3: two locked frames
      clear_tally();
      step(2 * H_TOT * V_TOT);
      chk("t3_valid_cnt", cnt_valid, 2 * HV * VV);
      chk("t3_frame_start_cnt", cnt_fs, 2);
      chk("t3_frame_start_pos", cnt_fs_bad, 0);
      chk("t3_locked", 32'(bus.locked), 1);
      chk("t3_line_err_cnt", cnt_le, 0);

      // T4: hsync one pixel early on line 3 (source skips a pixel)
      clear_tally();
      step(313);
      chk("t4_h_pre", 32'(bus.h_cnt), H_SS - 2);
      chk("t4_v_pre", 32'(bus.v_cnt), 3);
      sh = H_SS;
      step(1);
      chk("t4_line_err", 32'(bus.line_err), 1);
      chk("t4_err_count", 32'(bus.err_count), 1);
      chk("t4_unlocked", 32'(bus.locked), 0);
      chk("t4_h_resync", 32'(bus.h_cnt), H_SS);
      step(420 + H_TOT * V_TOT - 1);
      chk("t4_relock_before", 32'(bus.locked), 0);
      step(1);
      chk("t4_relock_after", 32'(bus.locked), 1);
      chk("t4_line_err_cnt", cnt_le, 1);
      chk("t4_frame_err_cnt", cnt_fe, 0);

      // T4b: one frame with vsync missing
      clear_tally();
      vs_force_hi = 1'b1;
      step(H_TOT * V_TOT);
      vs_force_hi = 1'b0;
      chk("t4b_frame_err", 32'(bus.frame_err), 1);
      chk("t4b_frame_err_cnt", cnt_fe, 1);
      chk("t4b_unlocked", 32'(bus.locked), 0);
      chk("t4b_err_count", 32'(bus.err_count), 2);
      chk("t4b_line_err_cnt", cnt_le, 0);

      // T5: hsync held high for 300 lines, err_count saturates
      clear_tally();
      hs_force_hi = 1'b1;
      step(252 * H_TOT);
      chk("t5_err_254", 32'(bus.err_count), 254);
      step(48 * H_TOT);
      chk("t5_err_sat", 32'(bus.err_count), 255);
      chk("t5_line_err_last", 32'(bus.line_err), 1);
      chk("t5_h_at_err", 32'(bus.h_cnt), H_SS);
      chk("t5_line_err_cnt", cnt_le, 300);
      chk("t5_frame_err_cnt", cnt_fe, 0);

      // T6: pixel strobe pause, then reset mid-frame
      step(3);
      chk("t6_h_pre", 32'(bus.h_cnt), H_SS + 3);
      chk("t6_v_pre", 32'(bus.v_cnt), 0);
      clear_tally();
      idle(50);
      chk("t6_h_frozen", 32'(bus.h_cnt), H_SS + 3);
      chk("t6_v_frozen", 32'(bus.v_cnt), 0);
      chk("t6_err_frozen", 32'(bus.err_count), 255);
      chk("t6_line_err_cnt", cnt_le, 0);
      chk("t6_frame_err_cnt", cnt_fe, 0);
      hs_force_hi = 1'b0;
      rst = 1'b0;
      bus.pix_ce = 1'b1;
      @(posedge clk); #1;
      chk_cleared("t6_rst");
      rst = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
